// File: rtl/wb_mem_decoder.sv
// wb_mem_decoder: pipelined Wishbone decoder; core port i_wb_*/o_wb_* fans out to NUM_DEV devices o_dev_wb_*/i_dev_wb_* via base/mask map, with outstanding tracking, unmapped error and timeout
module wb_mem_decoder #(
  parameter int NUM_DEV = 4,
  parameter logic [32*NUM_DEV-1:0] DEV_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [32*NUM_DEV-1:0] DEV_MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000},
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wb_cyc,
  input  logic                   i_wb_stb,
  input  logic                   i_wb_we,
  input  logic [31:0]            i_wb_addr,
  input  logic [31:0]            i_wb_data,
  input  logic [3:0]             i_wb_sel,
  output logic                   o_wb_ack,
  output logic                   o_wb_err,
  output logic                   o_wb_stall,
  output logic [31:0]            o_wb_data,
  output logic [NUM_DEV-1:0]     o_dev_wb_cyc,
  output logic [NUM_DEV-1:0]     o_dev_wb_stb,
  output logic [NUM_DEV-1:0]     o_dev_wb_we,
  output logic [32*NUM_DEV-1:0]  o_dev_wb_addr,
  output logic [32*NUM_DEV-1:0]  o_dev_wb_data,
  output logic [4*NUM_DEV-1:0]   o_dev_wb_sel,
  input  logic [NUM_DEV-1:0]     i_dev_wb_ack,
  input  logic [NUM_DEV-1:0]     i_dev_wb_stall,
  input  logic [32*NUM_DEV-1:0]  i_dev_wb_data
);
  localparam int IW = $clog2(NUM_DEV + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] UNMAPPED = IW'(NUM_DEV);
  logic [IW-1:0] target, owner_q, owner_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic abort_q, abort_d, err_q, err_d;
  logic busy, block, accept, done, fire;
  logic [NUM_DEV:0] ack_x, stall_x;
  logic [31:0] rdata [NUM_DEV+1];
  always_comb begin
    target = UNMAPPED;
    for (int i = NUM_DEV - 1; i >= 0; i--)
      if ((i_wb_addr & DEV_MASK[32*i +: 32]) == DEV_BASE[32*i +: 32]) target = IW'(i);
  end
  always_comb begin
    for (int i = 0; i < NUM_DEV; i++) rdata[i] = i_dev_wb_data[32*i +: 32];
    rdata[NUM_DEV] = '0;
  end
  assign ack_x = {1'b0, i_dev_wb_ack};
  assign stall_x = {1'b0, i_dev_wb_stall};
  assign busy = count_q != '0;
  assign block = (busy & target != owner_q) | count_q == CW'(MAX_OUTSTANDING) |
                 (target == UNMAPPED & busy) | abort_q;
  assign o_wb_stall = block | stall_x[target];
  assign accept = i_wb_cyc & i_wb_stb & !o_wb_stall & !i_rst;
  assign o_wb_ack = ack_x[owner_q] & busy & !i_rst;
  assign o_wb_err = err_q & i_wb_cyc & !i_rst;
  assign o_wb_data = rdata[owner_q];
  assign done = o_wb_ack | (err_q & busy);
  assign fire = busy & !done & i_wb_cyc & tcnt_q == TW'(TIMEOUT - 1);
  always_comb begin
    count_d = (!i_wb_cyc | fire) ? '0 : count_q + CW'(accept) - CW'(done);
    tcnt_d = (!busy | done | !i_wb_cyc | fire) ? '0 : tcnt_q + TW'(1);
    owner_d = accept ? target : owner_q;
    abort_d = fire;
    err_d = fire | (accept & target == UNMAPPED);
  end
  always_comb begin
    o_dev_wb_stb = '0;
    o_dev_wb_cyc = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      o_dev_wb_stb[i] = i_wb_stb & i_wb_cyc & target == IW'(i) & !block & !i_rst;
      o_dev_wb_cyc[i] = i_wb_cyc & (target == IW'(i) | (owner_q == IW'(i) & busy)) & !abort_q & !i_rst;
    end
  end
  assign o_dev_wb_we = {NUM_DEV{i_wb_we}};
  assign o_dev_wb_addr = {NUM_DEV{i_wb_addr}};
  assign o_dev_wb_data = {NUM_DEV{i_wb_data}};
  assign o_dev_wb_sel = {NUM_DEV{i_wb_sel}};
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
      owner_q <= '0;
      tcnt_q <= '0;
      abort_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      count_q <= count_d;
      owner_q <= owner_d;
      tcnt_q <= tcnt_d;
      abort_q <= abort_d;
      err_q <= err_d;
    end
  end
endmodule
